// File: rtl/running_minmax.sv
// rtl/running_minmax.sv - windowed signed min/max tracker with valid/ready report handshake
// Optional RUNNING_MINMAX_ARGIDX_EN adds out_min_idx/out_max_idx window positions.
module running_minmax #(
  parameter int N      = 32,
  parameter int WINDOW = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N-1:0]                in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [N-1:0]                out_min,
  output logic [N-1:0]                out_max,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        busy
`ifdef RUNNING_MINMAX_ARGIDX_EN
  ,
  output logic [$clog2(WINDOW)-1:0]   out_min_idx,
  output logic [$clog2(WINDOW)-1:0]   out_max_idx
`endif
);

  localparam int CW = $clog2(WINDOW);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    REPORT
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q;
  logic [N-1:0]   min_q, max_q;
  logic           accept;
  logic           last;
  logic           new_min, new_max;

`ifdef RUNNING_MINMAX_ARGIDX_EN
  logic [CW-1:0]  min_idx_q, max_idx_q;
  assign out_min_idx = min_idx_q;
  assign out_max_idx = max_idx_q;
`endif

  assign accept  = in_valid && in_ready;
  assign last    = (cnt_q == CW'(WINDOW - 1));
  // Strict compares so that ties keep the earlier sample.
  assign new_min = $signed(in_data) < $signed(min_q);
  assign new_max = $signed(max_q) < $signed(in_data);

  assign out_min = min_q;
  assign out_max = max_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b1;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = ACCUM;
      end
      ACCUM: begin
        busy = 1'b1;
        if (accept && last) state_d = REPORT;
      end
      REPORT: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      min_q <= '0;
      max_q <= '0;
`ifdef RUNNING_MINMAX_ARGIDX_EN
      min_idx_q <= '0;
      max_idx_q <= '0;
`endif
    end else if (accept) begin
      if (state_q == IDLE) begin
        cnt_q <= CW'(1);
        min_q <= in_data;
        max_q <= in_data;
`ifdef RUNNING_MINMAX_ARGIDX_EN
        min_idx_q <= '0;
        max_idx_q <= '0;
`endif
      end else begin
        cnt_q <= last ? '0 : cnt_q + CW'(1);
        if (new_min) begin
          min_q <= in_data;
`ifdef RUNNING_MINMAX_ARGIDX_EN
          min_idx_q <= cnt_q;
`endif
        end
        if (new_max) begin
          max_q <= in_data;
`ifdef RUNNING_MINMAX_ARGIDX_EN
          max_idx_q <= cnt_q;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_running_minmax.sv
// tb/tb_running_minmax.sv - directed self-checking bench for running_minmax (WINDOW=4)
module tb_running_minmax;

  localparam int N = 32;
  localparam int W = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  out_min;
  logic [N-1:0]  out_max;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
`ifdef RUNNING_MINMAX_ARGIDX_EN
  logic [1:0]    out_min_idx;
  logic [1:0]    out_max_idx;
`endif

  int checks = 0;
  int errors = 0;

  running_minmax #(.N(N), .WINDOW(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_min   (out_min),
    .out_max   (out_max),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
`ifdef RUNNING_MINMAX_ARGIDX_EN
    ,
    .out_min_idx (out_min_idx),
    .out_max_idx (out_max_idx)
`endif
  );

  always #5 clk = ~clk;

  // Called at a negedge; returns at the following negedge after the posedge accept.
  task automatic put(input logic [N-1:0] v);
    in_valid = 1'b1;
    in_data  = v;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    #2;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    put(32'd11);
    put(32'd12);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_flags valid=%b busy=%b ready=%b want 0 0 1", out_valid, busy, in_ready);
    end
    checks++;
    if (out_min !== 32'd0 || out_max !== 32'd0) begin
      errors++;
      $display("FAIL reset_data min=%h max=%h want 0 0", out_min, out_max);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    put(32'd5);
    put(32'hFFFF_FFFD);
    put(32'd7);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_pre_last valid=%b busy=%b want 0 1", out_valid, busy);
    end
    put(32'd0);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency valid=%b ready=%b busy=%b want 1 0 0", out_valid, in_ready, busy);
    end
    checks++;
    if (out_min !== 32'hFFFF_FFFD || out_max !== 32'h0000_0007) begin
      errors++;
      $display("FAIL basic_values min=%h max=%h want fffffffd 00000007", out_min, out_max);
    end
    handshake();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_release valid=%b ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_extremes();
    put(32'h8000_0000);
    put(32'h7FFF_FFFF);
    put(32'h0000_0000);
    put(32'hFFFF_FFFF);
    checks++;
    if (out_valid !== 1'b1 || out_min !== 32'h8000_0000 || out_max !== 32'h7FFF_FFFF) begin
      errors++;
      $display("FAIL extremes valid=%b min=%h max=%h want 1 80000000 7fffffff", out_valid, out_min, out_max);
    end
    handshake();
  endtask

  task automatic test_hold();
    put(32'd1);
    put(32'd2);
    put(32'd3);
    put(32'd4);
    in_valid = 1'b1;
    in_data  = 32'd9;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_min !== 32'd1 || out_max !== 32'd4) begin
        errors++;
        $display("FAIL hold_cycle%0d ready=%b valid=%b min=%h max=%h want 0 1 1 4", i, in_ready, out_valid, out_min, out_max);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_release valid=%b ready=%b busy=%b want 0 1 0", out_valid, in_ready, busy);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || out_min !== 32'd9 || out_max !== 32'd9) begin
      errors++;
      $display("FAIL hold_first busy=%b min=%h max=%h want 1 9 9", busy, out_min, out_max);
    end
    put(32'd10);
    put(32'd8);
    put(32'd9);
    checks++;
    if (out_valid !== 1'b1 || out_min !== 32'd8 || out_max !== 32'd10) begin
      errors++;
      $display("FAIL hold_next valid=%b min=%h max=%h want 1 8 10", out_valid, out_min, out_max);
    end
    handshake();
  endtask

  task automatic test_reset_mid();
    put(32'hFFFF_FFCE);
    put(32'd100);
    pulse_reset();
    checks++;
    if (busy !== 1'b0 || out_min !== 32'd0 || out_max !== 32'd0) begin
      errors++;
      $display("FAIL rstmid_clear busy=%b min=%h max=%h want 0 0 0", busy, out_min, out_max);
    end
    put(32'd1);
    put(32'd2);
    put(32'd3);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_early valid=%b want 0", out_valid);
    end
    put(32'd4);
    checks++;
    if (out_valid !== 1'b1 || out_min !== 32'd1 || out_max !== 32'd4) begin
      errors++;
      $display("FAIL rstmid_values valid=%b min=%h max=%h want 1 1 4", out_valid, out_min, out_max);
    end
    // Reset in the middle of a pending report also drops it.
    pulse_reset();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_report valid=%b ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int first = -1;
    int prev  = -1;
    int nrep  = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'd6;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (prev >= 0) begin
          checks++;
          if (c - prev !== W + 1) begin
            errors++;
            $display("FAIL b2b_period gap=%0d want %0d", c - prev, W + 1);
          end
        end else begin
          first = c;
        end
        prev = c;
        nrep++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (first !== W - 1 || nrep !== 6) begin
      errors++;
      $display("FAIL b2b_count first=%0d reports=%0d want %0d 6", first, nrep, W - 1);
    end
    @(negedge clk);
    pulse_reset();
  endtask

`ifdef RUNNING_MINMAX_ARGIDX_EN
  task automatic test_argidx();
    put(32'd4);
    put(32'd4);
    put(32'd2);
    put(32'd2);
    checks++;
    if (out_min !== 32'd2 || out_min_idx !== 2'd2 || out_max !== 32'd4 || out_max_idx !== 2'd0) begin
      errors++;
      $display("FAIL argidx min=%h@%0d max=%h@%0d want 2@2 4@0", out_min, out_min_idx, out_max, out_max_idx);
    end
    handshake();
  endtask
`endif

  initial begin
    rst       = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #12;
    rst = 1'b0;
    test_reset();
    test_basic();
    test_extremes();
    test_hold();
    test_reset_mid();
    test_back_to_back();
`ifdef RUNNING_MINMAX_ARGIDX_EN
    test_argidx();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
